// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: FSM encoding,
// length-field size, NOP fill word and the word-address helper.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_DATA = 3'd2,
    ST_CHK  = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } state_e;

  localparam int          LEN_BYTES = 4;
  localparam logic [31:0] NOP       = 32'h0000_0013;

  function automatic logic [31:0] word_addr(input logic [31:0] base,
                                            input logic [31:0] idx);
    return base + (idx << 2);
  endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Collects four bytes little-endian; word_valid fires combinationally with the
// fourth byte so the caller can register the completed word on that edge.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  byte_in,
  input  logic        byte_en,
  input  logic        clear,
  output logic [31:0] word_out,
  output logic        word_valid
);

  logic [1:0]  count_q;
  logic [23:0] shift_q;

  assign word_valid = byte_en && (count_q == 2'(LEN_BYTES - 1));
  assign word_out   = {byte_in, shift_q};

  // Earlier bytes drift toward bit 0 as newer ones arrive at the top.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count_q <= 2'd0;
      shift_q <= 24'd0;
    end else if (byte_en) begin
      count_q <= count_q + 2'd1;
      shift_q <= {byte_in, shift_q[23:8]};
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Byte-stream boot loader: receives a length, N data words and an XOR checksum,
// writes the words into instruction memory and holds the CPU until it succeeds.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          MAX_SIZE  = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [7:0]                   rx_data,
  input  logic                         rx_valid,
  output logic                         rx_ready,
  output logic                         mem_we,
  output logic [31:0]                  mem_addr,
  output logic [31:0]                  mem_wdata,
  output logic                         cpu_hold,
  output logic                         busy,
  output logic                         done,
  output logic                         error,
  output logic [$clog2(MAX_SIZE):0]    words_loaded
);

  localparam int WL = $clog2(MAX_SIZE) + 1;

  state_e        state_q;
  logic [WL-1:0] n_q;
  logic [WL-1:0] words_loaded_q;
  logic [7:0]    chk_q;
  logic          rx_ready_q, mem_we_q, cpu_hold_q, busy_q, done_q, error_q;
  logic [31:0]   mem_addr_q, mem_wdata_q;

  logic          accept_s, start_s, pk_en_s, word_vld_s;
  logic [31:0]   word_s;

  assign accept_s = rx_valid && rx_ready_q;
  assign start_s  = start && (state_q == ST_IDLE || state_q == ST_DONE || state_q == ST_ERR);
  assign pk_en_s  = accept_s && (state_q == ST_LEN || state_q == ST_DATA);

  byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .byte_in    (rx_data),
    .byte_en    (pk_en_s),
    .clear      (start_s),
    .word_out   (word_s),
    .word_valid (word_vld_s)
  );

  // Session FSM with all outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      n_q            <= '0;
      words_loaded_q <= '0;
      chk_q          <= 8'd0;
      rx_ready_q     <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= BASE_ADDR;
      mem_wdata_q    <= 32'd0;
      cpu_hold_q     <= 1'b1;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
    end else begin
      mem_we_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            state_q        <= ST_LEN;
            words_loaded_q <= '0;
            chk_q          <= 8'd0;
            rx_ready_q     <= 1'b1;
            cpu_hold_q     <= 1'b1;
            busy_q         <= 1'b1;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
          end
        end
        ST_LEN: begin
          if (word_vld_s) begin
            if (word_s > 32'(MAX_SIZE)) begin
              state_q    <= ST_ERR;
              rx_ready_q <= 1'b0;
              busy_q     <= 1'b0;
              error_q    <= 1'b1;
            end else if (word_s == 32'd0) begin
              state_q <= ST_CHK;
            end else begin
              n_q     <= word_s[WL-1:0];
              state_q <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (accept_s) begin
            chk_q <= chk_q ^ rx_data;
            if (word_vld_s) begin
              mem_we_q       <= 1'b1;
              mem_addr_q     <= word_addr(BASE_ADDR, 32'(words_loaded_q));
              mem_wdata_q    <= word_s;
              words_loaded_q <= words_loaded_q + WL'(1);
              if (words_loaded_q + WL'(1) == n_q) begin
                state_q <= ST_CHK;
              end
            end
          end
        end
        ST_CHK: begin
          if (accept_s) begin
            rx_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            if (rx_data == chk_q) begin
              state_q    <= ST_DONE;
              done_q     <= 1'b1;
              cpu_hold_q <= 1'b0;
            end else begin
              state_q <= ST_ERR;
              error_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          rx_ready_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign rx_ready     = rx_ready_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign cpu_hold     = cpu_hold_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  assign words_loaded = words_loaded_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: sessions are built from word lists, the
// expected writes are queued up front and a monitor matches every mem_we pulse.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int          MAX  = 1024;
  localparam logic [31:0] BASE = 32'h0000_0000;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] wl;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_valid = 1'b0;
  logic        rx_ready, mem_we, cpu_hold, busy, done, error;
  logic [31:0] mem_addr, mem_wdata;
  logic [$clog2(MAX):0] words_loaded;

  int          total = 0;
  int          bad = 0;
  exp_t        exp_q[$];
  logic [31:0] sess_words[8];
  logic [31:0] dut_mem[16];
  logic [31:0] ref_mem[16];
  logic [31:0] last_data, last_addr;

  imem_loader #(.MAX_SIZE(MAX), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (mem_addr[31:6] == 26'd0) dut_mem[mem_addr[5:2]] = mem_wdata;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_we: got addr 0x%08h data 0x%08h expected no write",
                 mem_addr, mem_wdata);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("we_addr", mem_addr, e.addr);
        check("we_data", mem_wdata, e.data);
        check("we_words_loaded", 32'(words_loaded), e.wl);
      end
    end
  end

  function automatic int pick_gap(input int gmode);
    if (gmode == 0) return 0;
    if (gmode == 1) return 1;
    return int'($urandom_range(0, 2));
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    repeat (gap) begin
      @(negedge clk);
      rx_valid = 1'b0;
    end
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    t = 0;
    while (rx_ready !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) begin
      total++;
      bad++;
      $display("FAIL rx_ready_timeout: got rx_ready=0 for 20 cycles expected 1");
    end
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic check_reset_state();
    check("rst_hold", 32'(cpu_hold), 32'd1);
    check("rst_ready", 32'(rx_ready), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_addr", mem_addr, BASE);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_words", 32'(words_loaded), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    last_data = 32'd0;
    last_addr = BASE;
    check_reset_state();
    check("rst_pending_writes", 32'(exp_q.size()), 32'd0);
  endtask

  // One load session; abort_after>0 resets once that many DATA bytes went in.
  task automatic run_session(input logic [31:0] n, input logic [7:0] flip,
                             input int gmode, input int abort_after);
    logic [7:0]  chk;
    logic [31:0] w;
    int          nb, t;
    exp_t        e;
    chk = 8'd0;
    nb  = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_busy", 32'(busy), 32'd1);
    check("start_hold", 32'(cpu_hold), 32'd1);
    check("start_words", 32'(words_loaded), 32'd0);
    for (int i = 0; i < LEN_BYTES; i++) send_byte(n[8*i +: 8], pick_gap(gmode));
    if (n > 32'(MAX)) begin
      repeat (3) @(negedge clk);
      check("len_err_error", 32'(error), 32'd1);
      check("len_err_ready", 32'(rx_ready), 32'd0);
      check("len_err_done", 32'(done), 32'd0);
      check("len_err_hold", 32'(cpu_hold), 32'd1);
      check("len_err_words", 32'(words_loaded), 32'd0);
      return;
    end
    for (int k = 0; k < int'(n); k++) begin
      w = sess_words[k];
      for (int b = 0; b < 4; b++) begin
        send_byte(w[8*b +: 8], pick_gap(gmode));
        chk ^= w[8*b +: 8];
        nb++;
        if (b == 3) begin
          e.addr = BASE + 32'(4 * k);
          e.data = w;
          e.wl   = 32'(k + 1);
          exp_q.push_back(e);
          ref_mem[k] = w;
          last_data  = w;
          last_addr  = e.addr;
        end
        if (nb == abort_after) begin
          do_reset();
          return;
        end
      end
    end
    send_byte(chk ^ flip, pick_gap(gmode));
    t = 0;
    while (done !== 1'b1 && error !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      total++;
      bad++;
      $display("FAIL end_timeout: got neither done nor error within 50 cycles");
    end
    repeat (2) @(negedge clk);
    check("end_pending_writes", 32'(exp_q.size()), 32'd0);
    check("end_done", 32'(done), (flip == 8'd0) ? 32'd1 : 32'd0);
    check("end_error", 32'(error), (flip == 8'd0) ? 32'd0 : 32'd1);
    check("end_hold", 32'(cpu_hold), (flip == 8'd0) ? 32'd0 : 32'd1);
    check("end_busy", 32'(busy), 32'd0);
    check("end_ready", 32'(rx_ready), 32'd0);
    check("end_words", 32'(words_loaded), n);
    check("end_wdata_hold", mem_wdata, last_data);
    check("end_addr_hold", mem_addr, last_addr);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      dut_mem[i] = NOP;
      ref_mem[i] = NOP;
    end
    last_data = 32'd0;
    last_addr = BASE;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_reset_state();

    sess_words[0] = 32'h0050_0093;
    sess_words[1] = 32'h00A0_0113;
    run_session(32'd2, 8'h00, 0, 0);
    run_session(32'd2, 8'h00, 1, 0);
    run_session(32'd2, 8'h01, 0, 0);
    run_session(32'd1025, 8'h00, 0, 0);
    run_session(32'd0, 8'h00, 0, 0);

    for (int i = 0; i < 3; i++) sess_words[i] = $urandom;
    run_session(32'd3, 8'h00, 0, 6);
    sess_words[0] = $urandom;
    run_session(32'd1, 8'h00, 0, 0);

    for (int s = 0; s < 6; s++) begin
      logic [31:0] n;
      logic [7:0]  flip;
      n = 32'($urandom_range(1, 6));
      for (int i = 0; i < 8; i++) sess_words[i] = $urandom;
      flip = ($urandom_range(0, 2) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
      run_session(n, flip, 2, 0);
    end

    repeat (4) @(negedge clk);
    for (int i = 0; i < 8; i++) check($sformatf("mem[%0d]", i), dut_mem[i], ref_mem[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The block SHALL have parameter MAX_SIZE, default 1024, meaning the instruction memory depth in 32-bit words.
REQ-002 The block SHALL have parameter BASE_ADDR, default 32'h00000000, meaning the byte address of the first word written.
REQ-003 Port clk, input, 1, SHALL be the single clock; all logic is rising-edge.
REQ-004 Port reset, input, 1, SHALL be a synchronous, active-high reset.
REQ-005 Port start, input, 1, SHALL request a new load session.
REQ-006 Port rx_data, input, 8, SHALL carry the incoming byte stream.
REQ-007 Port rx_valid, input, 1, SHALL mark rx_data as valid.
REQ-008 Port rx_ready, output, 1, SHALL indicate the loader accepts a byte.
REQ-009 Port mem_we, output, 1, SHALL be the instruction-memory write strobe.
REQ-010 Port mem_addr, output, 32, SHALL be the write byte address, word-aligned.
REQ-011 Port mem_wdata, output, 32, SHALL be the write data.
REQ-012 Port cpu_hold, output, 1, SHALL hold the CPU in reset while high.
REQ-013 Port busy, output, 1, SHALL be high while a session is in progress.
REQ-014 Port done, output, 1, SHALL indicate a successful load.
REQ-015 Port error, output, 1, SHALL indicate a failed load.
REQ-016 Port words_loaded, output, $clog2(MAX_SIZE)+1, SHALL report the number of words written in the current or last session.

Function
REQ-017 A byte SHALL be accepted only in a cycle where rx_valid and rx_ready are both high.
REQ-018 The FSM states SHALL be IDLE, LEN, DATA, CHK, DONE and ERR.
REQ-019 rx_ready SHALL be high in LEN, DATA and CHK only, and low in all other states.
REQ-020 From IDLE, DONE or ERR, start high SHALL go to LEN, clear words_loaded and the checksum, drop done and error, and raise cpu_hold and busy.
REQ-021 In LEN, exactly 4 bytes SHALL be accepted and interpreted little-endian as word count N.
REQ-022 After the 4th LEN byte: N > MAX_SIZE goes to ERR; N == 0 goes to CHK; otherwise the FSM goes to DATA.
REQ-023 In DATA, bytes SHALL be packed little-endian, with the first byte in bits [7:0].
REQ-024 In the cycle after the 4th byte of a word is accepted, mem_we SHALL pulse high for exactly 1 cycle, with:
  - mem_addr = BASE_ADDR + 4*words_loaded (pre-increment value);
  - mem_wdata = the assembled word.
REQ-025 words_loaded SHALL increment in the same cycle that mem_we is high.
REQ-026 DATA SHALL go to CHK once N words have been written.
REQ-027 A running checksum SHALL be the 8-bit XOR of all DATA bytes; LEN bytes are excluded.
REQ-028 In CHK, one byte SHALL be accepted; if it equals the checksum the FSM goes to DONE, otherwise to ERR.
REQ-029 Words already written before an ERR SHALL remain in memory; no rollback is performed.
REQ-030 In DONE: done = 1, cpu_hold = 0, busy = 0.
REQ-031 In ERR: error = 1, cpu_hold = 1, busy = 0.
REQ-032 start SHALL be ignored in LEN, DATA and CHK.
REQ-033 Gaps of any length in rx_valid SHALL not affect the result.
REQ-034 mem_we SHALL be 0 outside the defined write pulse, and mem_addr/mem_wdata SHALL hold their last values.
REQ-035 Back-to-back bytes, one per cycle, SHALL be sustained with no stall.

Reset
REQ-036 With reset high at a clock edge:
  - state = IDLE, cpu_hold = 1;
  - rx_ready, mem_we, busy, done and error = 0;
  - mem_addr = BASE_ADDR, mem_wdata = 0, words_loaded = 0;
  - the checksum and the partial word are cleared.
REQ-037 Reset SHALL abort any session mid-operation, and no further mem_we SHALL be issued.

Structure
REQ-038 Package imem_loader_pkg SHALL hold the FSM state encoding, the LEN byte count (4) and the NOP constant 32'h00000013 used by the memory initialisation.
REQ-039 A sub-module byte_packer SHALL perform 4-byte little-endian assembly, with ports byte_in, byte_en, clear, word_out and word_valid.
REQ-040 The memory itself SHALL not be part of this block; the write port connects to a writable instruction memory variant.

Verification
REQ-041 N=2, words 32'h00500093 and 32'h00A00113, correct checksum, contiguous stream -> two mem_we pulses at addresses 0x0 and 0x4 with those data; done=1; cpu_hold=0; words_loaded=2.
REQ-042 Same stream with rx_valid toggled every other cycle -> identical writes and end state.
REQ-043 Same data with checksum byte XORed by 0x01 -> two writes occur; error=1; cpu_hold=1; done=0.
REQ-044 LEN = 1025 with MAX_SIZE=1024 -> ERR immediately after the 4th byte; no mem_we; rx_ready=0.
REQ-045 N=0 followed by checksum byte 0x00 -> DONE; no mem_we; words_loaded=0.
REQ-046 Reset asserted after 6 DATA bytes of an N=3 session -> IDLE; one write only at 0x0; cpu_hold=1; then start with a fresh N=1 session -> write at 0x0 and done=1.
